key_cmd_ctrl: RTL and testbench
===============================

Name: key_cmd_ctrl

Overview:
- Upstream of the evolution controller. Consumes decoded PS/2 scan-code bytes (set 2).
- Maintains the edit cursor (cur_x, cur_y) and the run/edit mode flag.
- Emits one-cycle command pulses on envo_ctrl_cmd, which the evolution controller acts on (cell write, step, random, clear, pattern, run toggle).

Parameters:
- GRID_W, 64, board columns; cur_x range 0..GRID_W-1; legal range 2..256.
- GRID_H, 64, board rows; cur_y range 0..GRID_H-1; legal range 2..256.
- PREFIX_TIMEOUT, 1000000, clk cycles a prefix state may wait for its next byte before abandoning it.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- key_valid  in  1  one-cycle strobe; key_code valid this cycle
- key_code  in  8  scan-code byte from PS/2 receiver
- envo_ctrl_cmd  out  8  one-hot command pulse to evolution controller
- mode  out  1  0 = edit, 1 = run
- cur_x  out  8  cursor column
- cur_y  out  8  cursor row

Behaviour:
- Reset: envo_ctrl_cmd=0, mode=0, cur_x=0, cur_y=0, parser in IDLE, timeout counter=0. Reset wins over a simultaneous key_valid.
- All outputs are registered. Any response to a byte appears on the clock edge after the key_valid cycle (latency 1).
- Parser FSM, advancing only on key_valid:
  - IDLE: E0 -> EXT; F0 -> BRK; any other byte is a make code, decoded, stay IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> stay EXT; any other byte is an extended make, decoded -> IDLE.
  - BRK, EXT_BRK: the next byte is a release and is discarded -> IDLE.
- Timeout: in EXT, BRK or EXT_BRK the counter increments every cycle and clears on any key_valid. Reaching PREFIX_TIMEOUT-1 forces IDLE with no output.
- Cursor moves:
  - Up: W(1D) or E0 75 -> cur_y-1. Down: S(1B) or E0 72 -> cur_y+1.
  - Left: A(1C) or E0 6B -> cur_x-1. Right: D(23) or E0 74 -> cur_x+1.
  - All moves wrap: 0-1 -> GRID-1, GRID-1+1 -> 0.
  - Moves are allowed in both modes and produce no cmd pulse.
- Commands: exactly one bit of envo_ctrl_cmd is high for exactly one cycle.
  - [0] toggle cell, Space(29)
  - [1] set cell, E(24)
  - [2] kill cell, X(22)
  - [3] single step, N(31)
  - [4] random fill, R(2D)
  - [5] clear board, C(21)
  - [6] run/pause, Enter(5A); mode toggles on the same edge the pulse is asserted.
  - [7] load pattern, P(4D)
- In run mode (mode=1), bits 0,1,2,3,4,7 are suppressed: no pulse, no state change. Bits 5 and 6 remain active.
- Unmapped make codes and unmapped extended codes are ignored.
- Typematic repeats arrive as repeated make codes; each is processed as a fresh key press.
- With no key_valid, envo_ctrl_cmd returns to 0 on the next edge.

Optional Feature:
- Macro: CURSOR_FAST_EN.
- With it defined:
  - Tracks shift_held: set on make 12 or 59, cleared on their break (F0 12 / F0 59); cleared by rst.
  - While shift_held=1, each cursor move steps 8 cells, wrapping modulo GRID_W/GRID_H. Example: GRID_W=64, cur_x=60, right -> 4.
- Without it:
  - Shift codes are ignored as unmapped; all moves are single-step.
  - Break handling still discards the byte after F0.

Test Plan:
- Reset, then bytes 1C (left) and 1D (up) -> cur_x=63, cur_y=63; envo_ctrl_cmd stays 00.
- Edit mode, byte 29 -> envo_ctrl_cmd=01 for exactly 1 cycle, one edge after key_valid. Then F0 29 -> no pulse, parser back in IDLE.
- Byte 5A -> envo_ctrl_cmd=40 for 1 cycle, mode=1. Then 29 -> no pulse; 21 -> 20 pulse; 5A -> 40 pulse and mode=0.
- E0 74 x3 from cur_x=62 -> 63, 0, 1. E0 F0 74 -> no cursor change.
- Byte E0, then PREFIX_TIMEOUT idle cycles (sim with PREFIX_TIMEOUT=16), then 74 -> treated as non-extended unmapped code (ignored); cur_x unchanged. Repeat with a 23 byte -> cur_x+1.
- rst asserted same cycle as key_valid with 2D -> no pulse, all outputs 0. CURSOR_FAST_EN build: 12, 23, 23, F0 12, 23 -> cur_x 8, 16, 17.

Source files
------------

// File: rtl/key_cmd_ctrl_if.sv
// rtl/key_cmd_ctrl_if.sv - scan-code input and command/cursor output bundle for key_cmd_ctrl
// master drives scan-code bytes; slave (the controller) drives commands and cursor.
interface key_cmd_ctrl_if;
  logic       key_valid;
  logic [7:0] key_code;
  logic [7:0] envo_ctrl_cmd;
  logic       mode;
  logic [7:0] cur_x;
  logic [7:0] cur_y;

  modport master (
    output key_valid,
    output key_code,
    input  envo_ctrl_cmd,
    input  mode,
    input  cur_x,
    input  cur_y
  );

  modport slave (
    input  key_valid,
    input  key_code,
    output envo_ctrl_cmd,
    output mode,
    output cur_x,
    output cur_y
  );
endinterface

// File: rtl/key_cmd_ctrl.sv
// rtl/key_cmd_ctrl.sv - PS/2 set-2 parser driving cursor, run/edit mode and one-hot command pulses
// Optional build macro CURSOR_FAST_EN: shift (12/59) held makes cursor moves step 8 cells.
module key_cmd_ctrl #(
  parameter int GRID_W         = 64,
  parameter int GRID_H         = 64,
  parameter int PREFIX_TIMEOUT = 1000000
) (
  input  logic            clk,
  input  logic            rst,
  key_cmd_ctrl_if.slave   bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_EXT     = 2'd1;
  localparam logic [1:0] ST_BRK     = 2'd2;
  localparam logic [1:0] ST_EXT_BRK = 2'd3;

  localparam int          CW       = (PREFIX_TIMEOUT > 2) ? $clog2(PREFIX_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PREFIX_TIMEOUT - 1);
  localparam logic [8:0]  GW       = 9'(GRID_W);
  localparam logic [8:0]  GH       = 9'(GRID_H);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    cmd_q, cmd_d;
  logic          mode_q, mode_d;
  logic [7:0]    cx_q, cx_d;
  logic [7:0]    cy_q, cy_d;
  logic [8:0]    step_x, step_y;

  logic       make;
  logic       ext;
  logic [7:0] cmd_raw;

`ifdef CURSOR_FAST_EN
  localparam logic [8:0] FAST_X = 9'(8 % GRID_W);
  localparam logic [8:0] FAST_Y = 9'(8 % GRID_H);
  logic shift_q, shift_d;
  assign step_x = shift_q ? FAST_X : 9'd1;
  assign step_y = shift_q ? FAST_Y : 9'd1;
`else
  assign step_x = 9'd1;
  assign step_y = 9'd1;
`endif

  // step is always below n, so a single conditional subtract wraps correctly
  function automatic logic [7:0] wrap_inc(input logic [7:0] v, input logic [8:0] step,
                                          input logic [8:0] n);
    logic [8:0] s;
    s = {1'b0, v} + step;
    if (s >= n) s = s - n;
    return s[7:0];
  endfunction

  function automatic logic [7:0] wrap_dec(input logic [7:0] v, input logic [8:0] step,
                                          input logic [8:0] n);
    logic [8:0] s;
    s = {1'b0, v} + n - step;
    if (s >= n) s = s - n;
    return s[7:0];
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    cmd_raw = '0;
    make    = 1'b0;
    ext     = 1'b0;
`ifdef CURSOR_FAST_EN
    shift_d = shift_q;
`endif

    if (bus.key_valid) begin
      cnt_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (bus.key_code == 8'hE0)      state_d = ST_EXT;
          else if (bus.key_code == 8'hF0) state_d = ST_BRK;
          else                            make = 1'b1;
        end
        ST_EXT: begin
          if (bus.key_code == 8'hF0) state_d = ST_EXT_BRK;
          else if (bus.key_code != 8'hE0) begin
            make    = 1'b1;
            ext     = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_BRK: begin
`ifdef CURSOR_FAST_EN
          if (bus.key_code == 8'h12 || bus.key_code == 8'h59) shift_d = 1'b0;
`endif
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      // an abandoned prefix must not swallow the next unrelated byte
      if (cnt_q == CNT_LAST) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    if (make) begin
      case ({ext, bus.key_code})
        9'h01D, 9'h175: cy_d = wrap_dec(cy_q, step_y, GH);
        9'h01B, 9'h172: cy_d = wrap_inc(cy_q, step_y, GH);
        9'h01C, 9'h16B: cx_d = wrap_dec(cx_q, step_x, GW);
        9'h023, 9'h174: cx_d = wrap_inc(cx_q, step_x, GW);
        9'h029: cmd_raw = 8'h01;
        9'h024: cmd_raw = 8'h02;
        9'h022: cmd_raw = 8'h04;
        9'h031: cmd_raw = 8'h08;
        9'h02D: cmd_raw = 8'h10;
        9'h021: cmd_raw = 8'h20;
        9'h05A: cmd_raw = 8'h40;
        9'h04D: cmd_raw = 8'h80;
`ifdef CURSOR_FAST_EN
        9'h012, 9'h059: shift_d = 1'b1;
`endif
        default: ;
      endcase
    end

    // run mode keeps only clear and run/pause
    cmd_d = mode_q ? (cmd_raw & 8'h60) : cmd_raw;
    if (cmd_d[6]) mode_d = ~mode_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cmd_q   <= '0;
      mode_q  <= 1'b0;
      cx_q    <= '0;
      cy_q    <= '0;
`ifdef CURSOR_FAST_EN
      shift_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      mode_q  <= mode_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
`ifdef CURSOR_FAST_EN
      shift_q <= shift_d;
`endif
    end
  end

  assign bus.envo_ctrl_cmd = cmd_q;
  assign bus.mode          = mode_q;
  assign bus.cur_x         = cx_q;
  assign bus.cur_y         = cy_q;

endmodule

// File: tb/tb_key_cmd_ctrl.sv
// tb/tb_key_cmd_ctrl.sv - directed self-checking bench for key_cmd_ctrl
module tb_key_cmd_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  key_cmd_ctrl_if bus ();

  key_cmd_ctrl #(.GRID_W(64), .GRID_H(64), .PREFIX_TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] c);
    bus.key_valid = 1'b1;
    bus.key_code  = c;
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
    bus.key_code  = 8'h00;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_code  = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_cmd",  bus.envo_ctrl_cmd, 8'h00);
    chk("reset_mode", {7'd0, bus.mode},  8'h00);
    chk("reset_x",    bus.cur_x,         8'h00);
    chk("reset_y",    bus.cur_y,         8'h00);

    send(8'h1C);
    chk("left_wrap_x", bus.cur_x, 8'd63);
    chk("left_cmd",    bus.envo_ctrl_cmd, 8'h00);
    send(8'h1D);
    chk("up_wrap_y",   bus.cur_y, 8'd63);
    chk("up_cmd",      bus.envo_ctrl_cmd, 8'h00);

    send(8'h29);
    chk("toggle_pulse", bus.envo_ctrl_cmd, 8'h01);
    tick();
    chk("toggle_clear", bus.envo_ctrl_cmd, 8'h00);
    send(8'hF0);
    chk("brk_prefix", bus.envo_ctrl_cmd, 8'h00);
    send(8'h29);
    chk("brk_release", bus.envo_ctrl_cmd, 8'h00);
    send(8'h31);
    chk("step_after_brk", bus.envo_ctrl_cmd, 8'h08);

    send(8'h5A);
    chk("run_pulse", bus.envo_ctrl_cmd, 8'h40);
    chk("run_mode",  {7'd0, bus.mode}, 8'h01);
    send(8'h29);
    chk("run_suppress_toggle", bus.envo_ctrl_cmd, 8'h00);
    send(8'h4D);
    chk("run_suppress_pattern", bus.envo_ctrl_cmd, 8'h00);
    send(8'h21);
    chk("run_clear", bus.envo_ctrl_cmd, 8'h20);
    send(8'h5A);
    chk("pause_pulse", bus.envo_ctrl_cmd, 8'h40);
    chk("pause_mode",  {7'd0, bus.mode}, 8'h00);
    tick();
    chk("pause_clear", bus.envo_ctrl_cmd, 8'h00);

    send(8'h1C);
    chk("x_62", bus.cur_x, 8'd62);
    send(8'hE0); send(8'h74);
    chk("ext_right_63", bus.cur_x, 8'd63);
    send(8'hE0); send(8'h74);
    chk("ext_right_wrap0", bus.cur_x, 8'd0);
    send(8'hE0); send(8'h74);
    chk("ext_right_1", bus.cur_x, 8'd1);
    send(8'hE0); send(8'hF0); send(8'h74);
    chk("ext_break_x", bus.cur_x, 8'd1);
    send(8'hE0); send(8'h29);
    chk("ext_unmapped_cmd", bus.envo_ctrl_cmd, 8'h00);
    send(8'hE0); send(8'h72);
    chk("ext_down_y", bus.cur_y, 8'd0);

    send(8'hE0);
    repeat (16) tick();
    send(8'h74);
    chk("timeout_74_x", bus.cur_x, 8'd1);
    send(8'hE0);
    repeat (16) tick();
    send(8'h23);
    chk("timeout_23_x", bus.cur_x, 8'd2);

`ifdef CURSOR_FAST_EN
    send(8'h12);
    send(8'h23);
    chk("fast_right_10", bus.cur_x, 8'd10);
    send(8'h23);
    chk("fast_right_18", bus.cur_x, 8'd18);
    send(8'hF0); send(8'h12);
    send(8'h23);
    chk("slow_right_19", bus.cur_x, 8'd19);
`else
    send(8'h12);
    send(8'h23);
    chk("shift_ignored_x", bus.cur_x, 8'd3);
`endif

    send(8'h5A);
    chk("mode_before_rst", {7'd0, bus.mode}, 8'h01);
    rst           = 1'b1;
    bus.key_valid = 1'b1;
    bus.key_code  = 8'h2D;
    tick();
    bus.key_valid = 1'b0;
    bus.key_code  = 8'h00;
    chk("rst_key_cmd",  bus.envo_ctrl_cmd, 8'h00);
    chk("rst_key_mode", {7'd0, bus.mode},  8'h00);
    chk("rst_key_x",    bus.cur_x,         8'h00);
    chk("rst_key_y",    bus.cur_y,         8'h00);
    rst = 1'b0;
    tick();

`ifdef CURSOR_FAST_EN
    send(8'h12);
    send(8'h23);
    chk("plan_fast_8", bus.cur_x, 8'd8);
    send(8'h23);
    chk("plan_fast_16", bus.cur_x, 8'd16);
    send(8'hF0); send(8'h12);
    send(8'h23);
    chk("plan_fast_17", bus.cur_x, 8'd17);
`endif

    send(8'h2D);
    chk("random_pulse", bus.envo_ctrl_cmd, 8'h10);
    send(8'h24);
    chk("set_pulse", bus.envo_ctrl_cmd, 8'h02);
    send(8'h22);
    chk("kill_pulse", bus.envo_ctrl_cmd, 8'h04);
    send(8'h1B);
    chk("down_y", bus.cur_y, 8'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
